conv_mac_seq: RTL and testbench
===============================

// Module: conv_mac_seq
// PURPOSE
//  Parametrised, sequential successor of the 3x3 conv tap-sum: one KxK window per transaction, multiplied
//  against an internal weight/bias register file using LANES signed multipliers per cycle. The block adds
//  the weighted taps and a bias, then rounds, shifts, applies optional ReLU and saturates the result.
//  Sits between the line-buffer window generator and the feature-map writer, with valid/ready on both sides.
// PARAMETERS
//  DW     16  pixel width, signed two's complement
//  WW     16  weight/bias width, signed; fixed point with FRAC fractional bits
//  TAPS   9   taps per window (K*K)
//  LANES  3   multipliers per cycle, 1..TAPS
//  FRAC   8   fractional bits removed at output, 0..ACC_W-2
//  ACC_W  40  accumulator width; must be >= DW+WW+clog2(TAPS+1)
//  OUT_W  20  output width, signed
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous active-low reset
//  in_valid  in   1          window present on in_data
//  in_ready  out  1          block can accept a window
//  in_data   in   TAPS*DW    tap i at [i*DW +: DW]
//  relu_en   in   1          sampled with the window; 1 = clamp negatives to 0
//  out_valid out  1          result valid
//  out_ready in   1          sink accepts result
//  out_data  out  OUT_W      signed result
//  w_we      in   1          weight/bias write strobe
//  w_addr    in   clog2(TAPS+1)  0..TAPS-1 = weight i, TAPS = bias, higher = ignored
//  w_data    in   WW         write data
//  w_err     out  1          one-cycle pulse: write dropped because busy
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_ready=0 during reset, then 1 from the first clock after release.
//   out_valid=0, out_data=0, w_err=0, acc=0. All weights and bias = 0.
//  FSM IDLE -> MAC -> DONE -> IDLE. N = ceil(TAPS/LANES) MAC cycles.
//   IDLE: in_ready=1. On in_valid&in_ready, latch in_data and relu_en, set acc=sign-ext(bias)<<FRAC,
//    set grp=0 and go to MAC.
//   MAC: each cycle acc += sum of LANES products px[grp*LANES+j]*w[grp*LANES+j] (full-precision signed).
//    Lanes with index >= TAPS contribute 0. grp++. After grp==N-1, register the output and go to DONE.
//   DONE: out_valid=1 and out_data stable until out_ready. On out_valid&out_ready go to IDLE;
//    out_valid drops the next cycle. in_ready=0 in MAC and DONE; there is no overlap of transactions.
//  Latency: accept edge E -> out_valid high after edge E+N (TAPS=9, LANES=3: 3 cycles).
//   Throughput is 1 window per N+2 cycles when out_ready=1.
//  Output arithmetic: r = acc + (FRAC>0 ? 1<<(FRAC-1) : 0); r >>>= FRAC (arithmetic, round-half-up).
//   If relu_en and r<0, then r=0. Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  Weight port: a write in IDLE updates the register at the next edge. A write coinciding with an accepted
//   window updates the register, and the window uses the NEW value. Writes in MAC/DONE are dropped,
//   w_err=1 for 1 cycle. Writes with w_addr>TAPS are ignored silently.
//  The accumulator is sized so it cannot overflow; no wrap-around anywhere.
//  rst_n low mid-transaction: the transaction is aborted immediately. out_valid=0 and the weight file is
//   cleared, so weights must be reloaded.
//  in_data/relu_en changes after acceptance have no effect on the in-flight result.
// TESTING
//  1 Weights all 256 (1.0), bias 0, px 1..9, relu 0 -> out_data=45; out_valid 3 cycles after accept.
//  2 Rounding: w0=128, others 0, px0=1 -> 1; w0=127 -> 0; px0=-1, w0=128 -> 0 (half-up).
//  3 Saturation: all px=32767, all w=32767 -> 524287; all px=-32768, w=32767 -> -524288.
//  4 ReLU/bias: px all -100, w 256, bias 0: relu 0 -> -900, relu 1 -> 0.
//    bias=1000 (Q8: 256000>>8) with relu 1 -> 100.
//  5 Backpressure: out_ready=0 for 10 cycles -> out_valid/out_data held, in_ready=0.
//    The 2nd window is accepted only after the handshake.
//  6 w_we during MAC -> w_err pulse, weight unchanged. rst_n low in MAC -> out_valid=0 and a read-back
//    result with px=1 gives 0.

Source files
------------

// File: rtl/conv_mac_seq.sv
// Sequential KxK convolution MAC: one window per transaction, LANES signed
// multipliers per cycle against an internal weight/bias file, followed by
// round-half-up, arithmetic shift, optional ReLU and output saturation.
//
// state | meaning
// IDLE  | waiting for a window; weight writes accepted
// MAC   | accumulating LANES products per cycle for N cycles
// DONE  | result presented on out_data until out_ready
module conv_mac_seq #(
    parameter int DW    = 16,
    parameter int WW    = 16,
    parameter int TAPS  = 9,
    parameter int LANES = 3,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40,
    parameter int OUT_W = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [TAPS*DW-1:0]            in_data,
    input  logic                          relu_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    input  logic                          w_we,
    input  logic [$clog2(TAPS+1)-1:0]     w_addr,
    input  logic [WW-1:0]                 w_data,
    output logic                          w_err
);
    localparam int N  = (TAPS + LANES - 1) / LANES;
    localparam int NL = N * LANES;
    localparam int AW = $clog2(TAPS + 1);
    localparam int GW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (NL > 1) ? $clog2(NL) : 1;
    localparam int PW = DW + WW;

    localparam logic signed [ACC_W:0] RND =
        (FRAC > 0) ? ((ACC_W+1)'(1) <<< ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state_q;
    logic signed [DW-1:0]     px_q [NL];
    logic signed [WW-1:0]     w_q  [NL];
    logic signed [WW-1:0]     bias_q;
    logic [GW-1:0]            grp_q;
    logic                     relu_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     in_ready_q, out_valid_q, w_err_q;
    logic [OUT_W-1:0]         out_data_q, out_data_d;

    logic [NL*DW-1:0]         in_pad;
    logic signed [WW-1:0]     bias_eff;
    logic signed [ACC_W-1:0]  sum;
    logic signed [PW-1:0]     prod;
    logic [IW-1:0]            idx;
    logic signed [ACC_W:0]    r;

    // Taps beyond TAPS in the last group read zero-padded pixel slots.
    assign in_pad = (NL*DW)'(in_data);

    // A bias write landing on the accept edge must seed the accumulator.
    assign bias_eff = (w_we && w_addr == AW'(TAPS)) ? w_data : bias_q;

    // One group of lane products, the running sum, and the output post-processing.
    always_comb begin
        sum = '0;
        idx = '0;
        prod = '0;
        for (int j = 0; j < LANES; j++) begin
            idx  = IW'(int'(grp_q) * LANES + j);
            prod = px_q[idx] * w_q[idx];
            sum  = sum + ACC_W'(prod);
        end
        acc_d = acc_q + sum;
        r = $signed({acc_d[ACC_W-1], acc_d}) + RND;
        r = r >>> FRAC;
        if (relu_q && r[ACC_W]) r = '0;
        if (r > SAT_MAX)      out_data_d = SAT_MAX[OUT_W-1:0];
        else if (r < SAT_MIN) out_data_d = SAT_MIN[OUT_W-1:0];
        else                  out_data_d = r[OUT_W-1:0];
    end

    // Control FSM, datapath registers and the weight/bias file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            w_err_q     <= 1'b0;
            acc_q       <= '0;
            grp_q       <= '0;
            relu_q      <= 1'b0;
            bias_q      <= '0;
            for (int i = 0; i < NL; i++) begin
                px_q[i] <= '0;
                w_q[i]  <= '0;
            end
        end else begin
            w_err_q <= w_we && (state_q != IDLE) && (w_addr <= AW'(TAPS));
            if (w_we && state_q == IDLE) begin
                if (w_addr < AW'(TAPS))       w_q[IW'(w_addr)] <= w_data;
                else if (w_addr == AW'(TAPS)) bias_q <= w_data;
            end
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        for (int i = 0; i < NL; i++) px_q[i] <= in_pad[i*DW +: DW];
                        relu_q     <= relu_en;
                        acc_q      <= ACC_W'(bias_eff) <<< FRAC;
                        grp_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    grp_q <= grp_q + 1'b1;
                    if (grp_q == GW'(N - 1)) begin
                        out_data_q  <= out_data_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign w_err     = w_err_q;
endmodule

// File: tb/tb_conv_mac_seq.sv
// Directed bench for conv_mac_seq with a queue-based scoreboard and monitor.
module tb_conv_mac_seq;
    localparam int DW = 16, WW = 16, TAPS = 9, LANES = 3, FRAC = 8, ACC_W = 40, OUT_W = 20;
    localparam int N = 3;

    logic                 clk = 1'b0, rst_n = 1'b0;
    logic                 in_valid = 1'b0, relu_en = 1'b0, out_ready = 1'b1, w_we = 1'b0;
    logic                 in_ready, out_valid, w_err;
    logic [TAPS*DW-1:0]   in_data = '0;
    logic [OUT_W-1:0]     out_data;
    logic [3:0]           w_addr = '0;
    logic [WW-1:0]        w_data = '0;

    int checks = 0, failures = 0;
    int exp_q[$];
    int px_v[TAPS];

    conv_mac_seq #(.DW(DW), .WW(WW), .TAPS(TAPS), .LANES(LANES), .FRAC(FRAC),
                   .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .relu_en(relu_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .w_we(w_we),
        .w_addr(w_addr), .w_data(w_data), .w_err(w_err));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake pops one expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %0d expected none", $signed(out_data));
            end else begin
                check("out_data", $signed(out_data), exp_q.pop_front());
            end
        end
    end

    task automatic pack();
        for (int i = 0; i < TAPS; i++) in_data[i*DW +: DW] = DW'(px_v[i]);
    endtask

    task automatic write_w(input int a, input int v);
        w_we = 1'b1; w_addr = 4'(a); w_data = WW'(v);
        tick();
        w_we = 1'b0;
    endtask

    task automatic set_all_w(input int v);
        for (int i = 0; i < TAPS; i++) write_w(i, v);
    endtask

    task automatic set_all_px(input int v);
        for (int i = 0; i < TAPS; i++) px_v[i] = v;
    endtask

    task automatic wait_in_ready(input string name);
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) check({name, "_in_ready_timeout"}, 0, 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
        if (exp_q.size() != 0) begin
            check({name, "_drain_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Issue one window; optionally write the bias on the accept edge.
    task automatic send(input string name, input bit relu, input int exp, input bit do_drain,
                        input bit bias_wr, input int bias_v);
        int n;
        pack();
        relu_en = relu;
        in_valid = 1'b1;
        if (bias_wr) begin w_we = 1'b1; w_addr = 4'(TAPS); w_data = WW'(bias_v); end
        wait_in_ready(name);
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        w_we = 1'b0;
        for (int i = 0; i < TAPS; i++) in_data[i*DW +: DW] = DW'($urandom);
        relu_en = ~relu;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check({name, "_latency"}, n, N);
        if (do_drain) drain(name);
    endtask

    int bad;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_w_err", w_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        check("in_ready_after_rst", in_ready, 1);

        // 1: unity weights, px 1..9
        set_all_w(256);
        for (int i = 0; i < TAPS; i++) px_v[i] = i + 1;
        send("t1_sum", 1'b0, 45, 1'b1, 1'b0, 0);

        // 2: rounding
        set_all_w(0);
        write_w(0, 128);
        set_all_px(5); px_v[0] = 1;
        send("t2_half", 1'b0, 1, 1'b1, 1'b0, 0);
        write_w(0, 127);
        send("t2_below_half", 1'b0, 0, 1'b1, 1'b0, 0);
        write_w(0, 128);
        px_v[0] = -1;
        send("t2_neg_half", 1'b0, 0, 1'b1, 1'b0, 0);

        // 3: saturation
        set_all_w(32767);
        set_all_px(32767);
        send("t3_sat_pos", 1'b0, 524287, 1'b1, 1'b0, 0);
        set_all_px(-32768);
        send("t3_sat_neg", 1'b0, -524288, 1'b1, 1'b0, 0);

        // 4: relu and bias (bias written on the accept edge)
        set_all_w(256);
        set_all_px(-100);
        send("t4_norelu", 1'b0, -900, 1'b1, 1'b0, 0);
        send("t4_relu", 1'b1, 0, 1'b1, 1'b0, 0);
        send("t4_bias", 1'b1, 100, 1'b1, 1'b1, 1000);
        write_w(TAPS, 0);

        // 5: backpressure
        out_ready = 1'b0;
        for (int i = 0; i < TAPS; i++) px_v[i] = i + 1;
        send("t5_first", 1'b0, 45, 1'b0, 1'b0, 0);
        set_all_px(2);
        pack();
        in_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (!(out_valid === 1'b1 && $signed(out_data) == 45 && in_ready === 1'b0)) bad++;
            tick();
        end
        check("t5_hold_violations", bad, 0);
        check("t5_in_ready_blocked", in_ready, 0);
        exp_q.push_back(18);
        out_ready = 1'b1;
        tick();
        check("t5_out_valid_drop", out_valid, 0);
        check("t5_in_ready_after_hs", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("t5_second_accepted", in_ready, 0);
        drain("t5_second");

        // 6: write during MAC is dropped
        for (int i = 0; i < TAPS; i++) px_v[i] = i + 1;
        pack();
        in_valid = 1'b1;
        wait_in_ready("t6");
        exp_q.push_back(45);
        tick();
        in_valid = 1'b0;
        w_we = 1'b1; w_addr = 4'd0; w_data = '0;
        tick();
        w_we = 1'b0;
        check("t6_w_err_pulse", w_err, 1);
        tick();
        check("t6_w_err_clear", w_err, 0);
        drain("t6_first");
        send("t6_weight_kept", 1'b0, 45, 1'b1, 1'b0, 0);

        // 6b: reset mid-MAC aborts and clears weights
        pack();
        in_valid = 1'b1;
        wait_in_ready("t6b");
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6b_rst_out_valid", out_valid, 0);
        check("t6b_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        check("t6b_no_stale_output", bad, 0);
        set_all_px(1);
        send("t6b_cleared_weights", 1'b0, 0, 1'b1, 1'b0, 0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
